// File: rtl/z80_screen_snoop.sv
// z80_screen_snoop: snoops Z80 writes to 0x4000-0x5AFF into CLK-domain video RAM strobes (optional border port via BORDER_CAPTURE_EN)
module z80_screen_snoop #(
  parameter int SYNC_STAGES = 2,
  parameter int WR_FILTER   = 2,
  parameter int LED_HOLD    = 2**22
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] A,
  input  logic [7:0]  D,
  input  logic        MRQ,
  input  logic        IORQ,
  input  logic        WR,
  input  logic        M1,
  output logic        mem_we,
  output logic [12:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        LED1
`ifdef BORDER_CAPTURE_EN
  ,
  output logic [2:0]  border
`endif
);
  localparam int CW = $clog2(WR_FILTER + 1);
  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam int LW = $clog2(LED_HOLD + 1);
  localparam logic [CW-1:0] FL = CW'(WR_FILTER - 1);
  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0][15:0] a_sy;
  logic [SYNC_STAGES-1:0][7:0] d_sy;
  logic [SYNC_STAGES-1:0][3:0] c_sy;
  logic [15:0] a_lat;
  logic [7:0] d_lat;
  logic [CW-1:0] cnt, cnt_n;
  logic [FW-1:0] fill;
  logic [LW-1:0] led_cnt;
  logic mrq_s, iorq_s, wr_s, m1_s, mem_cyc, io_cyc, cyc, latch, is_io, armed, filled;
  assign {mrq_s, iorq_s, wr_s, m1_s} = c_sy[SYNC_STAGES-1];
  assign mem_cyc = !mrq_s & !wr_s & iorq_s;
  assign io_cyc = !iorq_s & !wr_s & m1_s;
`ifdef BORDER_CAPTURE_EN
  assign cyc = mem_cyc | io_cyc;
`else
  assign cyc = mem_cyc;
`endif
  assign filled = fill == FW'(SYNC_STAGES);
  assign mem_we = state == CAPTURE & !is_io & a_lat[15:13] == 3'b010 & a_lat[12:0] <= 13'h1AFF;
  assign mem_addr = a_lat[12:0];
  assign mem_data = d_lat;
  assign LED1 = led_cnt != '0;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    latch = 1'b0;
    if (state == IDLE) begin
      cnt_n = armed & cyc ? cnt + 1'b1 : '0;
      if (armed & cyc & cnt == FL) begin
        cnt_n = '0;
        latch = 1'b1;
        state_n = CAPTURE;
      end
    end else if (state == CAPTURE) begin
      state_n = HOLD;
    end else begin
      cnt_n = wr_s ? cnt + 1'b1 : '0;
      if (wr_s & cnt == FL) begin
        cnt_n = '0;
        state_n = IDLE;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      a_sy <= '0;
      d_sy <= '0;
      c_sy <= '1;
      a_lat <= '0;
      d_lat <= '0;
      is_io <= 1'b0;
      fill <= '0;
      armed <= 1'b0;
      led_cnt <= '0;
    end else begin
      a_sy <= {a_sy[SYNC_STAGES-2:0], A};
      d_sy <= {d_sy[SYNC_STAGES-2:0], D};
      c_sy <= {c_sy[SYNC_STAGES-2:0], {MRQ, IORQ, WR, M1}};
      state <= state_n;
      cnt <= cnt_n;
      a_lat <= latch ? a_sy[SYNC_STAGES-1] : a_lat;
      d_lat <= latch ? d_sy[SYNC_STAGES-1] : d_lat;
      is_io <= latch ? io_cyc : is_io;
      fill <= filled ? fill : fill + 1'b1;
      armed <= armed | (filled & wr_s);
      led_cnt <= mem_we ? LW'(LED_HOLD - 1) : led_cnt != '0 ? led_cnt - 1'b1 : led_cnt;
    end
  end
`ifdef BORDER_CAPTURE_EN
  always_ff @(posedge CLK) begin
    if (RST) border <= 3'd0;
    else if (state == CAPTURE & is_io & !a_lat[0]) border <= d_lat[2:0];
  end
`endif
endmodule
